// File: rtl/sprite_pkg.sv
// sprite_pkg: shared animation state encoding and colour defaults for the sprite block
package sprite_pkg;
    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [15:0] SPR_BG_COLOR   = 16'hFFFF;
    localparam logic [15:0] SPR_TRANSP_KEY = 16'h0000;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: animation FSM that divides frame_tick pulses and steps the frame index
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAMES    = 4,
    parameter int FRAME_DIV = 8,
    parameter int FI_W      = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            anim_en_i,
    input  logic            oneshot_i,
    input  logic            frame_tick_i,
    output logic [FI_W-1:0] frame_idx_o,
    output logic            anim_done_o
);
    localparam int DIV_W = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;

    logic [1:0]      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [FI_W-1:0] frame_q, frame_d;
    logic            wrap, last;

    assign wrap = div_q == DIV_W'(FRAME_DIV - 1);
    assign last = frame_q == FI_W'(FRAMES - 1);
    assign frame_idx_o = frame_q;
    assign anim_done_o = state_q == ST_DONE;

    // next state: frame only moves on a counted tick; leaving DONE rewinds to frame 0
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        frame_d = frame_q;
        case (state_q)
            ST_STOP: state_d = anim_en_i ? ST_RUN : ST_STOP;
            ST_RUN: begin
                if (!anim_en_i) begin
                    state_d = ST_STOP;
                end else if (frame_tick_i) begin
                    div_d = wrap ? '0 : div_q + 1'b1;
                    if (wrap && last && oneshot_i)
                        state_d = ST_DONE;
                    else if (wrap)
                        frame_d = last ? '0 : frame_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!anim_en_i) begin
                    state_d = ST_STOP;
                    div_d   = '0;
                    frame_d = '0;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // state, divider and frame registers with synchronous reset overriding every input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            frame_q <= frame_d;
        end
    end
endmodule

// File: rtl/sprite_anim_color.sv
// sprite_anim_color: sprite hit test, flipped ROM addressing, colour-key transparency and animation
module sprite_anim_color
    import sprite_pkg::*;
#(
    parameter int          SPR_W      = 133,
    parameter int          SPR_H      = 39,
    parameter int          FRAMES     = 4,
    parameter int          FRAME_DIV  = 8,
    parameter logic [15:0] TRANSP_KEY = SPR_TRANSP_KEY,
    parameter logic [15:0] BG_COLOR   = SPR_BG_COLOR,
    parameter int          ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES),
    parameter int          FI_W       = FRAMES > 1 ? $clog2(FRAMES) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [9:0]        posx,
    input  logic [8:0]        posy,
    input  logic              isplay,
    input  logic              flip_h,
    input  logic              anim_en,
    input  logic              oneshot,
    input  logic              frame_tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       color,
    output logic              is_display,
    output logic [FI_W-1:0]   frame_idx,
    output logic              anim_done
);
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic [9:0]  dx, col;
    logic [8:0]  dy;
    logic        hit;
    logic [15:0] color_q, color_d;
    logic        disp_q, disp_d;

    sprite_anim_ctrl #(
        .FRAMES    (FRAMES),
        .FRAME_DIV (FRAME_DIV),
        .FI_W      (FI_W)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .anim_en_i    (anim_en),
        .oneshot_i    (oneshot),
        .frame_tick_i (frame_tick),
        .frame_idx_o  (frame_idx),
        .anim_done_o  (anim_done)
    );

    // window ends are one bit wider so a sprite near the screen edge does not wrap
    assign x_end = {1'b0, posx} + 11'(SPR_W);
    assign y_end = {1'b0, posy} + 10'(SPR_H);
    assign hit = isplay && x >= posx && {1'b0, x} < x_end && y >= posy && {1'b0, y} < y_end;
    assign dx  = x - posx;
    assign dy  = y - posy;
    assign col = flip_h ? 10'(SPR_W - 1) - dx : dx;
    assign rom_addr = ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H) + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
    assign color      = color_q;
    assign is_display = disp_q;

    // opaque sprite pixels pass through, everything else shows background
    always_comb begin
        disp_d  = hit && rom_data != TRANSP_KEY;
        color_d = disp_d ? rom_data : BG_COLOR;
    end

    // one-cycle registered pixel output
    always_ff @(posedge clk) begin
        if (rst) begin
            color_q <= BG_COLOR;
            disp_q  <= 1'b0;
        end else begin
            color_q <= color_d;
            disp_q  <= disp_d;
        end
    end
endmodule

// File: tb/tb_sprite_anim_color.sv
// tb_sprite_anim_color: scoreboard bench with a tick-counting animation model and a ROM image
module tb_sprite_anim_color;
    localparam int SPR_W = 133, SPR_H = 39, FRAMES = 4, FRAME_DIV = 8;
    localparam int DEPTH = SPR_W * SPR_H * FRAMES;

    typedef struct { logic [15:0] color; logic disp; } exp_t;

    logic        clk = 1'b0;
    logic        rst, isplay, flip_h, anim_en, oneshot, frame_tick;
    logic [9:0]  x, posx;
    logic [8:0]  y, posy;
    logic [14:0] rom_addr;
    logic [15:0] rom_data, color;
    logic        is_display, anim_done;
    logic [1:0]  frame_idx;

    logic [15:0] mem [DEPTH];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0, n_bad = 0;
    int          m_mode = 0, m_cnt = 0;

    sprite_anim_color dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy),
        .isplay(isplay), .flip_h(flip_h), .anim_en(anim_en), .oneshot(oneshot),
        .frame_tick(frame_tick), .rom_addr(rom_addr), .rom_data(rom_data),
        .color(color), .is_display(is_display), .frame_idx(frame_idx), .anim_done(anim_done)
    );

    always #5 clk = ~clk;

    assign rom_data = (int'(rom_addr) < DEPTH) ? mem[int'(rom_addr)] : 16'h0000;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every edge produces a pixel, compare it with the oldest expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("color", int'(color), int'(mon_e.color));
            chk("is_display", int'(is_display), int'(mon_e.disp));
        end
    end

    // one clock: check combinational outputs, queue the pixel expectation, advance the model
    task automatic step();
        int fr, dx, col, addr;
        bit hit;
        exp_t e;
        #1;
        fr = m_cnt / FRAME_DIV;
        e.color = 16'hFFFF;
        e.disp = 1'b0;
        if (!rst) begin
            chk("frame_idx", int'(frame_idx), fr);
            chk("anim_done", int'(anim_done), int'(m_mode == 2));
            hit = isplay && int'(x) >= int'(posx) && int'(x) < int'(posx) + SPR_W
                  && int'(y) >= int'(posy) && int'(y) < int'(posy) + SPR_H;
            if (hit) begin
                dx = int'(x) - int'(posx);
                col = flip_h ? SPR_W - 1 - dx : dx;
                addr = fr * SPR_W * SPR_H + (int'(y) - int'(posy)) * SPR_W + col;
                chk("rom_addr", int'(rom_addr), addr);
                if (mem[addr] != 16'h0000) begin
                    e.color = mem[addr];
                    e.disp = 1'b1;
                end
            end
        end
        exp_q.push_back(e);
        if (rst) begin
            m_mode = 0;
            m_cnt = 0;
        end else if (m_mode == 0) begin
            if (anim_en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!anim_en) m_mode = 0;
            else if (frame_tick) begin
                if (m_cnt + 1 == FRAMES * FRAME_DIV) begin
                    if (oneshot) begin
                        m_mode = 2;
                        m_cnt = (FRAMES - 1) * FRAME_DIV;
                    end else m_cnt = 0;
                end else m_cnt++;
            end
        end else if (!anim_en) begin
            m_mode = 0;
            m_cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic scan_rand();
        x = 10'(int'(posx) + int'($urandom_range(0, 140)) - 4);
        y = 9'(int'(posy) + int'($urandom_range(0, 46)) - 4);
        flip_h = 1'($urandom_range(0, 1));
    endtask

    task automatic tick_run(int n);
        for (int i = 0; i < n; i++) begin
            scan_rand();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            scan_rand();
            step();
            step();
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        mem[0] = 16'h1234;
        mem[5] = 16'h0000;
        rst = 1'b1; isplay = 1'b0; flip_h = 1'b0; anim_en = 1'b0; oneshot = 1'b0; frame_tick = 1'b0;
        posx = 10'd100; posy = 9'd50; x = 10'd0; y = 9'd0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();
        isplay = 1'b1; x = 10'd100; y = 9'd50;
        step();
        flip_h = 1'b1; x = 10'd232;
        step();
        x = 10'd233;
        step();
        flip_h = 1'b0; x = 10'd105;
        step();
        isplay = 1'b0;
        for (int i = 0; i < 6; i++) begin
            scan_rand();
            step();
        end
        isplay = 1'b1;
        // wrapping animation; the first tick coincides with STOP->RUN and is ignored
        anim_en = 1'b1;
        tick_run(17);
        x = 10'd100; y = 9'd50; flip_h = 1'b0;
        #1 chk("corner_frame2_addr", int'(rom_addr), 10374);
        step();
        tick_run(20);
        // oneshot run to completion, then release
        rst = 1'b1;
        step();
        rst = 1'b0; oneshot = 1'b1;
        step();
        tick_run(36);
        #1 chk("oneshot_frame", int'(frame_idx), 3);
        chk("oneshot_done", int'(anim_done), 1);
        anim_en = 1'b0;
        step();
        #1 chk("release_frame", int'(frame_idx), 0);
        chk("release_done", int'(anim_done), 0);
        // reset mid-animation coincident with a tick
        oneshot = 1'b0; anim_en = 1'b1;
        step();
        tick_run(16);
        rst = 1'b1; frame_tick = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("rst_frame", int'(frame_idx), 0);
        chk("rst_done", int'(anim_done), 0);
        chk("rst_color", int'(color), 16'hFFFF);
        chk("rst_disp", int'(is_display), 0);
        step();
        frame_tick = 1'b0;
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) begin
                posx = 10'($urandom_range(0, 1023));
                posy = 9'($urandom_range(0, 511));
                oneshot = 1'($urandom_range(0, 1));
            end
            scan_rand();
            isplay = $urandom_range(0, 7) != 0;
            anim_en = $urandom_range(0, 31) != 0;
            frame_tick = $urandom_range(0, 2) == 0;
            rst = $urandom_range(0, 299) == 0;
            step();
        end
        rst = 1'b0; frame_tick = 1'b0;
        step();
        repeat (3) @(negedge clk);
        chk("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_anim_color.md
SPRITE_ANIM_COLOR -- requirements
Module: sprite_anim_color

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): SPR_W, 133, sprite width in pixels.
REQ-002 SPR_H, 39, sprite height in pixels.
REQ-003 FRAMES, 4, number of animation frames stored back-to-back in ROM (frame-major, row-major).
REQ-004 FRAME_DIV, 8, frame_tick pulses per animation step (>=1).
REQ-005 TRANSP_KEY, 16'h0000, ROM colour treated as transparent.
REQ-006 BG_COLOR, 16'hFFFF, colour output when not displaying.
REQ-007 ADDR_W, clog2(SPR_W*SPR_H*FRAMES), ROM address width (15 at defaults).
REQ-008 The block SHALL have ports (name, direction, width, meaning): clk  in  1  pixel clock; all logic is on its rising edge.
REQ-009 rst  in  1  reset; synchronous and active-high.
REQ-010 x  in  10  scan column from vgac; y  in  9  scan row from vgac.
REQ-011 posx  in  10  and  posy  in  9  give the sprite top-left corner.
REQ-012 isplay  in  1  sprite enable.
REQ-013 flip_h  in  1  horizontal mirror.
REQ-014 anim_en  in  1  run animation.
REQ-015 oneshot  in  1  stop on the last frame instead of wrapping.
REQ-016 frame_tick  in  1  one-cycle pulse per video frame (vsync).
REQ-017 rom_addr  out  ADDR_W  combinational address to external async-read ROM; rom_data  in  16  ROM word for rom_addr, same cycle.
REQ-018 color  out  16  registered pixel colour; is_display  out  1  registered opaque-hit flag.
REQ-019 frame_idx  out  clog2(FRAMES)  current frame; anim_done  out  1  oneshot completed.

Function
REQ-020 hit SHALL equal isplay AND x>=posx AND x<posx+SPR_W AND y>=posy AND y<posy+SPR_H, with sums computed one bit wider than the operands (no wrap at screen edge).
REQ-021 col SHALL equal x-posx, or SPR_W-1-(x-posx) when flip_h=1; row SHALL equal y-posy.
REQ-022 rom_addr SHALL equal frame_idx*SPR_W*SPR_H + row*SPR_W + col, and SHALL be don't-care when hit=0.
REQ-023 Latency SHALL be 1 clk: on each edge, color<=rom_data and is_display<=1 if hit and rom_data!=TRANSP_KEY; otherwise color<=BG_COLOR and is_display<=0.
REQ-024 An animation FSM SHALL have states STOP, RUN and DONE.
REQ-025 STOP->RUN when anim_en=1; RUN->STOP when anim_en=0 (frame_idx and divider hold their values).
REQ-026 In RUN, a divider SHALL count frame_tick pulses 0..FRAME_DIV-1; on the pulse that wraps it, frame_idx SHALL advance.
REQ-027 frame_idx SHALL wrap from FRAMES-1 to 0 when oneshot=0.
REQ-028 When oneshot=1 and an advance is due at FRAMES-1, the FSM SHALL go to DONE, hold FRAMES-1 and set anim_done=1.
REQ-029 DONE->STOP with frame_idx=0, divider=0 and anim_done=0 when anim_en=0.
REQ-030 frame_idx SHALL change only on a frame_tick cycle, so no frame tears mid-scan.
REQ-031 When FRAMES=1, frame_idx SHALL stay at 0.
REQ-032 A frame_tick in the same cycle as a STOP->RUN transition SHALL NOT count.

Reset
REQ-033 When rst=1 at an edge, the block SHALL set color=BG_COLOR, is_display=0, frame_idx=0, divider=0, anim_done=0 and state=STOP.
REQ-034 Reset SHALL override every input including frame_tick, and SHALL be honoured mid-animation.

Structure
REQ-035 The FSM state encoding and the BG_COLOR/TRANSP_KEY defaults SHALL live in a shared package (sprite_pkg).
REQ-036 The animation FSM plus divider SHALL be a sub-module (sprite_anim_ctrl); ROM instances SHALL stay outside the block.

Verification
REQ-037 posx=100, posy=50, x=100, y=50, flip_h=0, frame 0 -> rom_addr=0; the next cycle color=rom_data and is_display=1.
REQ-038 Same position, x=232, flip_h=1 -> rom_addr=0; x=233 -> is_display=0 and color=16'hFFFF one cycle later.
REQ-039 Sprite pixel with rom_data=16'h0000 -> is_display=0 and color=16'hFFFF; isplay=0 -> same response everywhere.
REQ-040 anim_en=1, oneshot=0, FRAME_DIV=8 -> frame_idx steps 0,1,2,3,0 on every 8th frame_tick; at frame 2, rom_addr at corner=10374.
REQ-041 oneshot=1 -> after 32 ticks frame_idx=3 and anim_done=1, held; anim_en=0 -> frame_idx=0 and anim_done=0.
REQ-042 rst=1 at frame_idx=2 coincident with frame_tick -> next cycle all outputs at reset values and state=STOP.
